// File: rtl/n101_qspi_flashmap_2_pkg.sv
// ----------------------------------------------------------------------------
// n101_qspi_flashmap_2_pkg
// Shared definitions for the XIP read sequencer: FSM state encoding, link
// protocol codes, op direction codes and a helper that clamps the configured
// address length to the four bytes the link can carry.
// ----------------------------------------------------------------------------
package n101_qspi_flashmap_2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FLUSH     = 3'd1,
        ST_CMD       = 3'd2,
        ST_ADDR      = 3'd3,
        ST_PAD       = 3'd4,
        ST_DATA_REQ  = 3'd5,
        ST_DATA_RESP = 3'd6
    } state_t;

    // Lane protocol encodings understood by the media
    localparam logic [1:0] PROTO_SINGLE = 2'd0;
    localparam logic [1:0] PROTO_DUAL   = 2'd1;
    localparam logic [1:0] PROTO_QUAD   = 2'd2;

    // Op direction seen by the media
    localparam logic IODIR_TX = 1'b1;
    localparam logic IODIR_RX = 1'b0;

    // Every command, address and data op moves one byte
    localparam logic [7:0] BYTE_BITS = 8'd8;

    // Address lengths 5..7 behave as 4
    function automatic logic [2:0] clamp_addr_len(input logic [2:0] len);
        return (len > 3'd4) ? 3'd4 : len;
    endfunction

endpackage

// File: rtl/n101_qspi_flashmap_2.sv
// ----------------------------------------------------------------------------
// n101_qspi_flashmap_2
// Memory-mapped XIP read sequencer. Each accepted single-byte read request is
// turned into a sequence of link ops for the downstream QSPI media:
// optional command byte, 0..4 address bytes (MSB first), optional pad op and
// finally a receive op. When a request continues the previous one (same
// open chip select, address = last + 1) only the receive op is reissued.
//
// Ports
//   clock, reset            sole clock, synchronous active-high reset
//   io_en                   XIP enable; low = no requests, release CS
//   io_ctrl_*               live instruction format (cmd/addr/pad/data)
//   io_addr_*               request channel (valid/ready, next + held addr)
//   io_data_*               read byte channel (valid/ready, byte)
//   io_link_tx_*, io_link_cnt, io_link_fmt_*, io_link_cs_*
//                           op channel towards the media
//   io_link_rx_valid/bits   received byte pulse from the media
//   io_link_active          media currently holds CS asserted
// ----------------------------------------------------------------------------
module n101_qspi_flashmap_2
    import n101_qspi_flashmap_2_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_en,
    input  logic              io_ctrl_insn_cmd_en,
    input  logic [7:0]        io_ctrl_insn_cmd_code,
    input  logic [1:0]        io_ctrl_insn_cmd_proto,
    input  logic [2:0]        io_ctrl_insn_addr_len,
    input  logic [1:0]        io_ctrl_insn_addr_proto,
    input  logic [7:0]        io_ctrl_insn_pad_code,
    input  logic [3:0]        io_ctrl_insn_pad_cnt,
    input  logic [1:0]        io_ctrl_insn_data_proto,
    input  logic              io_ctrl_fmt_endian,
    input  logic              io_addr_valid,
    output logic              io_addr_ready,
    input  logic [ADDR_W-1:0] io_addr_bits_next,
    input  logic [ADDR_W-1:0] io_addr_bits_hold,
    output logic              io_data_valid,
    input  logic              io_data_ready,
    output logic [7:0]        io_data_bits,
    output logic              io_link_tx_valid,
    input  logic              io_link_tx_ready,
    output logic [7:0]        io_link_tx_bits,
    output logic [7:0]        io_link_cnt,
    output logic [1:0]        io_link_fmt_proto,
    output logic              io_link_fmt_endian,
    output logic              io_link_fmt_iodir,
    output logic              io_link_cs_set,
    output logic              io_link_cs_clear,
    output logic              io_link_cs_hold,
    input  logic              io_link_rx_valid,
    input  logic [7:0]        io_link_rx_bits,
    input  logic              io_link_active
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_reg,      state_next;
    logic [ADDR_W-1:0]   addr_reg,       addr_next;
    logic [ADDR_W-1:0]   exp_addr_reg,   exp_addr_next;
    logic                merge_ok_reg,   merge_ok_next;
    logic [2:0]          byte_cnt_reg,   byte_cnt_next;
    logic                data_valid_reg, data_valid_next;
    logic [7:0]          data_bits_reg,  data_bits_next;
    logic                tx_valid_reg,   tx_valid_next;
    logic [7:0]          tx_bits_reg,    tx_bits_next;
    logic [7:0]          tx_cnt_reg,     tx_cnt_next;
    logic [1:0]          tx_proto_reg,   tx_proto_next;
    logic                tx_iodir_reg,   tx_iodir_next;

    logic                fire;
    logic                accept;
    logic                merge_hit;
    logic                addr_ready;
    logic                cs_clear;
    logic [ADDR_W-1:0]   hold_inc;
    logic [31:0]         addr_ext;
    logic [7:0]          addr_bytes [4];
    logic [1:0]          addr_idx;

    assign fire = tx_valid_reg & io_link_tx_ready;

    // ------------------------------------------------------------------
    // Address byte selection. The latched address is zero-extended to
    // 32 bits so that lengths beyond ADDR_W/8 emit leading zero bytes.
    // byte_cnt counts down from the length, so byte (cnt-1) is the one
    // on the wire, giving MSB-first order.
    // ------------------------------------------------------------------
    assign addr_ext = 32'(addr_reg);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_addr_byte
            assign addr_bytes[gi] = addr_ext[8*gi +: 8];
        end
    endgenerate

    assign addr_idx = 2'(byte_cnt_reg - 3'd1);

    // ------------------------------------------------------------------
    // Merge check: the request must continue exactly where the open
    // transaction left off, from both our and the requester's view.
    // ------------------------------------------------------------------
    assign hold_inc  = io_addr_bits_hold + ADDR_W'(1);
    assign merge_hit = merge_ok_reg & io_link_active &
                       (io_addr_bits_next == exp_addr_reg) &
                       (io_addr_bits_next == hold_inc);

    assign accept = addr_ready & io_addr_valid;

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        exp_addr_next   = exp_addr_reg;
        merge_ok_next   = merge_ok_reg;
        byte_cnt_next   = byte_cnt_reg;
        data_valid_next = data_valid_reg;
        data_bits_next  = data_bits_reg;
        tx_valid_next   = tx_valid_reg;
        tx_bits_next    = tx_bits_reg;
        tx_cnt_next     = tx_cnt_reg;
        tx_proto_next   = tx_proto_reg;
        tx_iodir_next   = tx_iodir_reg;
        addr_ready      = 1'b0;
        cs_clear        = 1'b0;

        if (data_valid_reg && io_data_ready) begin
            data_valid_next = 1'b0;
        end

        // Op states follow one pattern: while an op is offered, wait for
        // the fire and then advance; otherwise either load the next op
        // (fields stay frozen in the tx registers until it fires) or skip.
        case (state_reg)
            ST_IDLE: begin
                // Holding off until the byte is consumed guarantees the
                // receive op is never issued with a byte still pending.
                addr_ready = io_en & ~data_valid_reg;
                if (!io_en) begin
                    merge_ok_next = 1'b0;
                    cs_clear      = io_link_active;
                end
                if (accept) begin
                    addr_next = io_addr_bits_next;
                    if (merge_hit) begin
                        state_next = ST_DATA_REQ;
                    end else if (io_link_active) begin
                        state_next = ST_FLUSH;
                    end else begin
                        state_next = ST_CMD;
                    end
                end
            end

            ST_FLUSH: begin
                cs_clear = 1'b1;
                if (!io_link_active) begin
                    state_next = ST_CMD;
                end
            end

            ST_CMD: begin
                if (tx_valid_reg) begin
                    if (fire) begin
                        tx_valid_next = 1'b0;
                        byte_cnt_next = clamp_addr_len(io_ctrl_insn_addr_len);
                        state_next    = ST_ADDR;
                    end
                end else if (io_ctrl_insn_cmd_en) begin
                    tx_valid_next = 1'b1;
                    tx_bits_next  = io_ctrl_insn_cmd_code;
                    tx_cnt_next   = BYTE_BITS;
                    tx_proto_next = io_ctrl_insn_cmd_proto;
                    tx_iodir_next = IODIR_TX;
                end else begin
                    byte_cnt_next = clamp_addr_len(io_ctrl_insn_addr_len);
                    state_next    = ST_ADDR;
                end
            end

            ST_ADDR: begin
                if (tx_valid_reg) begin
                    if (fire) begin
                        tx_valid_next = 1'b0;
                        byte_cnt_next = byte_cnt_reg - 3'd1;
                    end
                end else if (byte_cnt_reg != 3'd0) begin
                    tx_valid_next = 1'b1;
                    tx_bits_next  = addr_bytes[addr_idx];
                    tx_cnt_next   = BYTE_BITS;
                    tx_proto_next = io_ctrl_insn_addr_proto;
                    tx_iodir_next = IODIR_TX;
                end else begin
                    state_next = ST_PAD;
                end
            end

            ST_PAD: begin
                if (tx_valid_reg) begin
                    if (fire) begin
                        tx_valid_next = 1'b0;
                        state_next    = ST_DATA_REQ;
                    end
                end else if (io_ctrl_insn_pad_cnt != 4'd0) begin
                    // Pad/mode bits travel on the address lanes
                    tx_valid_next = 1'b1;
                    tx_bits_next  = io_ctrl_insn_pad_code;
                    tx_cnt_next   = 8'(io_ctrl_insn_pad_cnt);
                    tx_proto_next = io_ctrl_insn_addr_proto;
                    tx_iodir_next = IODIR_TX;
                end else begin
                    state_next = ST_DATA_REQ;
                end
            end

            ST_DATA_REQ: begin
                if (tx_valid_reg) begin
                    if (fire) begin
                        tx_valid_next = 1'b0;
                        state_next    = ST_DATA_RESP;
                    end
                end else begin
                    tx_valid_next = 1'b1;
                    tx_bits_next  = 8'h00;
                    tx_cnt_next   = BYTE_BITS;
                    tx_proto_next = io_ctrl_insn_data_proto;
                    tx_iodir_next = IODIR_RX;
                end
            end

            ST_DATA_RESP: begin
                if (io_link_rx_valid) begin
                    data_bits_next  = io_link_rx_bits;
                    data_valid_next = 1'b1;
                    exp_addr_next   = addr_reg + ADDR_W'(1);
                    merge_ok_next   = 1'b1;
                    state_next      = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= '0;
            exp_addr_reg   <= '0;
            merge_ok_reg   <= 1'b0;
            byte_cnt_reg   <= 3'd0;
            data_valid_reg <= 1'b0;
            data_bits_reg  <= 8'h00;
            tx_valid_reg   <= 1'b0;
            tx_bits_reg    <= 8'h00;
            tx_cnt_reg     <= 8'h00;
            tx_proto_reg   <= PROTO_SINGLE;
            tx_iodir_reg   <= IODIR_RX;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            exp_addr_reg   <= exp_addr_next;
            merge_ok_reg   <= merge_ok_next;
            byte_cnt_reg   <= byte_cnt_next;
            data_valid_reg <= data_valid_next;
            data_bits_reg  <= data_bits_next;
            tx_valid_reg   <= tx_valid_next;
            tx_bits_reg    <= tx_bits_next;
            tx_cnt_reg     <= tx_cnt_next;
            tx_proto_reg   <= tx_proto_next;
            tx_iodir_reg   <= tx_iodir_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign io_addr_ready      = addr_ready;
    assign io_data_valid      = data_valid_reg;
    assign io_data_bits       = data_bits_reg;
    assign io_link_tx_valid   = tx_valid_reg;
    assign io_link_tx_bits    = tx_bits_reg;
    assign io_link_cnt        = tx_cnt_reg;
    assign io_link_fmt_proto  = tx_proto_reg;
    assign io_link_fmt_iodir  = tx_iodir_reg;
    assign io_link_fmt_endian = io_ctrl_fmt_endian;
    assign io_link_cs_set     = 1'b1;
    assign io_link_cs_clear   = cs_clear;
    // CS is kept open after every op so sequential reads can be merged
    assign io_link_cs_hold    = (state_reg != ST_IDLE) && (state_reg != ST_FLUSH);

endmodule

// File: tb/tb_n101_qspi_flashmap_2.sv
module tb_n101_qspi_flashmap_2;

    localparam int ADDR_W = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic              io_en;
    logic              io_ctrl_insn_cmd_en;
    logic [7:0]        io_ctrl_insn_cmd_code;
    logic [1:0]        io_ctrl_insn_cmd_proto;
    logic [2:0]        io_ctrl_insn_addr_len;
    logic [1:0]        io_ctrl_insn_addr_proto;
    logic [7:0]        io_ctrl_insn_pad_code;
    logic [3:0]        io_ctrl_insn_pad_cnt;
    logic [1:0]        io_ctrl_insn_data_proto;
    logic              io_ctrl_fmt_endian;
    logic              io_addr_valid;
    logic              io_addr_ready;
    logic [ADDR_W-1:0] io_addr_bits_next;
    logic [ADDR_W-1:0] io_addr_bits_hold;
    logic              io_data_valid;
    logic              io_data_ready;
    logic [7:0]        io_data_bits;
    logic              io_link_tx_valid;
    logic              io_link_tx_ready;
    logic [7:0]        io_link_tx_bits;
    logic [7:0]        io_link_cnt;
    logic [1:0]        io_link_fmt_proto;
    logic              io_link_fmt_endian;
    logic              io_link_fmt_iodir;
    logic              io_link_cs_set;
    logic              io_link_cs_clear;
    logic              io_link_cs_hold;
    logic              io_link_rx_valid;
    logic [7:0]        io_link_rx_bits;
    logic              io_link_active;

    always #5 clock = ~clock;

    n101_qspi_flashmap_2 #(.ADDR_W(ADDR_W)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .io_en                  (io_en),
        .io_ctrl_insn_cmd_en    (io_ctrl_insn_cmd_en),
        .io_ctrl_insn_cmd_code  (io_ctrl_insn_cmd_code),
        .io_ctrl_insn_cmd_proto (io_ctrl_insn_cmd_proto),
        .io_ctrl_insn_addr_len  (io_ctrl_insn_addr_len),
        .io_ctrl_insn_addr_proto(io_ctrl_insn_addr_proto),
        .io_ctrl_insn_pad_code  (io_ctrl_insn_pad_code),
        .io_ctrl_insn_pad_cnt   (io_ctrl_insn_pad_cnt),
        .io_ctrl_insn_data_proto(io_ctrl_insn_data_proto),
        .io_ctrl_fmt_endian     (io_ctrl_fmt_endian),
        .io_addr_valid          (io_addr_valid),
        .io_addr_ready          (io_addr_ready),
        .io_addr_bits_next      (io_addr_bits_next),
        .io_addr_bits_hold      (io_addr_bits_hold),
        .io_data_valid          (io_data_valid),
        .io_data_ready          (io_data_ready),
        .io_data_bits           (io_data_bits),
        .io_link_tx_valid       (io_link_tx_valid),
        .io_link_tx_ready       (io_link_tx_ready),
        .io_link_tx_bits        (io_link_tx_bits),
        .io_link_cnt            (io_link_cnt),
        .io_link_fmt_proto      (io_link_fmt_proto),
        .io_link_fmt_endian     (io_link_fmt_endian),
        .io_link_fmt_iodir      (io_link_fmt_iodir),
        .io_link_cs_set         (io_link_cs_set),
        .io_link_cs_clear       (io_link_cs_clear),
        .io_link_cs_hold        (io_link_cs_hold),
        .io_link_rx_valid       (io_link_rx_valid),
        .io_link_rx_bits        (io_link_rx_bits),
        .io_link_active         (io_link_active)
    );

    typedef struct {
        logic [7:0] bits;
        logic [7:0] cnt;
        logic [1:0] proto;
        logic       iodir;
    } op_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        logic        flush;
    } rd_t;

    op_t op_q[$];
    rd_t rd_q[$];

    int          checks = 0;
    int          failures = 0;
    logic [31:0] cur_addr = 32'd0;
    logic [31:0] last_addr = 32'd0;
    bit          force_stall = 1'b0;
    bit          m_ok = 1'b0;
    logic [31:0] m_exp = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Flash content: an arbitrary but fixed function of the byte address
    function automatic logic [7:0] flash_byte(input logic [31:0] a);
        logic [7:0] m;
        m = a[7:0] * 8'd29;
        return m ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
    endfunction

    // ------------------------------------------------------------------
    // Media model + op monitor
    // ------------------------------------------------------------------
    initial begin
        bit  rx_pending;
        int  rx_delay;
        int  clr_cnt;
        int  clr_thr;
        op_t e;
        rx_pending = 1'b0;
        rx_delay = 0;
        clr_cnt = 0;
        clr_thr = 2;
        io_link_tx_ready = 1'b0;
        io_link_rx_valid = 1'b0;
        io_link_rx_bits = 8'h00;
        io_link_active = 1'b0;
        forever begin
            @(negedge clock);
            #1;
            if (reset) begin
                io_link_tx_ready = 1'b0;
                io_link_rx_valid = 1'b0;
                io_link_active = 1'b0;
                rx_pending = 1'b0;
                clr_cnt = 0;
                continue;
            end
            io_link_rx_valid = 1'b0;
            if (rx_pending) begin
                if (rx_delay == 0) begin
                    io_link_rx_valid = 1'b1;
                    io_link_rx_bits = flash_byte(cur_addr);
                    rx_pending = 1'b0;
                end else begin
                    rx_delay--;
                end
            end else if ($urandom_range(0, 19) == 0) begin
                // stray pulse while no receive is outstanding
                io_link_rx_valid = 1'b1;
                io_link_rx_bits = 8'($urandom);
            end
            if (io_link_cs_clear && io_link_active) begin
                clr_cnt++;
                if (clr_cnt >= clr_thr) begin
                    io_link_active = 1'b0;
                    clr_cnt = 0;
                    clr_thr = $urandom_range(1, 4);
                end
            end else begin
                clr_cnt = 0;
            end
            io_link_tx_ready = force_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (io_link_tx_valid && io_link_tx_ready) begin
                io_link_active = 1'b1;
                if (op_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL op_unexpected actual=bits 0x%0h iodir %0b required=no op",
                             io_link_tx_bits, io_link_fmt_iodir);
                end else begin
                    e = op_q.pop_front();
                    check("op_bits", 32'(io_link_tx_bits), 32'(e.bits));
                    check("op_cnt", 32'(io_link_cnt), 32'(e.cnt));
                    check("op_proto", 32'(io_link_fmt_proto), 32'(e.proto));
                    check("op_iodir", 32'(io_link_fmt_iodir), 32'(e.iodir));
                end
                check("op_cs_hold", 32'(io_link_cs_hold), 32'd1);
                check("op_endian", 32'(io_link_fmt_endian), 32'(io_ctrl_fmt_endian));
                check("op_while_data_valid", 32'(io_data_valid), 32'd0);
                if (!io_link_fmt_iodir) begin
                    rx_pending = 1'b1;
                    rx_delay = $urandom_range(0, 3);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read-data monitor
    // ------------------------------------------------------------------
    initial begin
        int  hold_cnt;
        bit  clear_seen;
        int  n_rd;
        rd_t r;
        hold_cnt = 0;
        clear_seen = 1'b0;
        n_rd = 0;
        io_data_ready = 1'b0;
        forever begin
            @(negedge clock);
            #1;
            if (reset) begin
                io_data_ready = 1'b0;
                hold_cnt = 0;
                clear_seen = 1'b0;
                continue;
            end
            if (io_en && io_link_cs_clear) clear_seen = 1'b1;
            if (hold_cnt > 0) begin
                hold_cnt--;
                io_data_ready = 1'b0;
            end else if (io_data_valid && $urandom_range(0, 9) == 0) begin
                hold_cnt = 10;
                io_data_ready = 1'b0;
            end else begin
                io_data_ready = ($urandom_range(0, 2) != 0);
            end
            if (io_data_valid) begin
                check("addr_ready_while_data_valid", 32'(io_addr_ready), 32'd0);
            end
            if (io_data_valid && io_data_ready) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL data_unexpected actual=0x%0h required=no data", io_data_bits);
                end else begin
                    r = rd_q.pop_front();
                    check("data_bits", 32'(io_data_bits), 32'(r.data));
                    check("flush_seen", 32'(clear_seen), 32'(r.flush));
                    check("ops_done_before_data", 32'(op_q.size()), 32'd0);
                    $display("rd %0d addr=0x%08h data=0x%02h flush=%0b", n_rd, r.addr,
                             io_data_bits, r.flush);
                    n_rd++;
                end
                clear_seen = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus + reference model
    // ------------------------------------------------------------------
    task automatic set_ctrl(input bit ce, input logic [7:0] code, input logic [1:0] cp,
                            input logic [2:0] al, input logic [1:0] ap,
                            input logic [7:0] pc, input logic [3:0] pn,
                            input logic [1:0] dp, input bit en);
        io_ctrl_insn_cmd_en     = ce;
        io_ctrl_insn_cmd_code   = code;
        io_ctrl_insn_cmd_proto  = cp;
        io_ctrl_insn_addr_len   = al;
        io_ctrl_insn_addr_proto = ap;
        io_ctrl_insn_pad_code   = pc;
        io_ctrl_insn_pad_cnt    = pn;
        io_ctrl_insn_data_proto = dp;
        io_ctrl_fmt_endian      = en;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 4000 && rd_q.size() != 0; i++) @(negedge clock);
        if (rd_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d pending required=0", rd_q.size());
            rd_q.delete();
            op_q.delete();
        end
    endtask

    // Disable XIP, change the instruction format, enable again
    task automatic reconfig(input bit ce, input logic [7:0] code, input logic [1:0] cp,
                            input logic [2:0] al, input logic [1:0] ap,
                            input logic [7:0] pc, input logic [3:0] pn,
                            input logic [1:0] dp, input bit en);
        wait_idle();
        @(negedge clock);
        io_en = 1'b0;
        m_ok = 1'b0;
        repeat ($urandom_range(2, 8)) @(negedge clock);
        set_ctrl(ce, code, cp, al, ap, pc, pn, dp, en);
        @(negedge clock);
        io_en = 1'b1;
    endtask

    task automatic random_reconfig();
        logic [3:0] pn;
        pn = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        reconfig($urandom_range(0, 3) != 0, 8'($urandom), 2'($urandom_range(0, 2)),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 2)), 8'($urandom), pn,
                 2'($urandom_range(0, 2)), 1'($urandom));
    endtask

    task automatic do_req(input logic [31:0] addr, input logic [31:0] hold);
        bit ok;
        bit merge;
        bit flush;
        int n;
        op_t o;
        ok = 1'b0;
        @(negedge clock);
        io_addr_bits_next = addr;
        io_addr_bits_hold = hold;
        io_addr_valid = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            #2;
            if (io_addr_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=not accepted required=accept addr 0x%08h", addr);
            io_addr_valid = 1'b0;
            return;
        end
        // Expected behaviour of this read, from the open-CS situation
        merge = m_ok && io_link_active && (addr == m_exp) && (addr == hold + 32'd1);
        flush = !merge && io_link_active;
        if (!merge) begin
            if (io_ctrl_insn_cmd_en) begin
                o = '{io_ctrl_insn_cmd_code, 8'd8, io_ctrl_insn_cmd_proto, 1'b1};
                op_q.push_back(o);
            end
            n = (io_ctrl_insn_addr_len > 3'd4) ? 4 : int'(io_ctrl_insn_addr_len);
            for (int b = n; b >= 1; b--) begin
                o = '{8'(addr >> (8 * (b - 1))), 8'd8, io_ctrl_insn_addr_proto, 1'b1};
                op_q.push_back(o);
            end
            if (io_ctrl_insn_pad_cnt != 4'd0) begin
                o = '{io_ctrl_insn_pad_code, 8'(io_ctrl_insn_pad_cnt),
                      io_ctrl_insn_addr_proto, 1'b1};
                op_q.push_back(o);
            end
        end
        o = '{8'h00, 8'd8, io_ctrl_insn_data_proto, 1'b0};
        op_q.push_back(o);
        rd_q.push_back('{addr, flash_byte(addr), flush});
        cur_addr = addr;
        last_addr = addr;
        m_ok = 1'b1;
        m_exp = addr + 32'd1;
        @(posedge clock);
        #1;
        io_addr_valid = 1'b0;
    endtask

    initial begin
        bit seen_tx;
        reset = 1'b1;
        io_en = 1'b0;
        io_addr_valid = 1'b0;
        io_addr_bits_next = '0;
        io_addr_bits_hold = '0;
        set_ctrl(1'b1, 8'h03, 2'd0, 3'd3, 2'd0, 8'h00, 4'd0, 2'd0, 1'b0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #2;
        check("rst_tx_valid", 32'(io_link_tx_valid), 32'd0);
        check("rst_data_valid", 32'(io_data_valid), 32'd0);
        check("rst_data_bits", 32'(io_data_bits), 32'd0);
        check("rst_cs_clear", 32'(io_link_cs_clear), 32'd0);
        check("rst_addr_ready", 32'(io_addr_ready), 32'd0);
        check("cs_set", 32'(io_link_cs_set), 32'd1);

        // Plain read, merged follow-on, then a jump forcing a flush
        @(negedge clock);
        io_en = 1'b1;
        do_req(32'h0001_2345, 32'h0000_0000);
        do_req(32'h0001_2346, 32'h0001_2345);
        do_req(32'h0000_0100, 32'h0001_2346);
        // Address wrap merges across 0xFFFFFFFF -> 0
        do_req(32'hFFFF_FFFF, 32'h1234_5678);
        do_req(32'h0000_0000, 32'hFFFF_FFFF);
        // Quad fast read with mode byte
        reconfig(1'b1, 8'hEB, 2'd0, 3'd3, 2'd2, 8'hFF, 4'd6, 2'd2, 1'b1);
        do_req(32'h0000_1000, 32'h0000_0000);
        do_req(32'h0000_1001, 32'h0000_1000);
        // Sequential address but requester's held address disagrees
        do_req(32'h0000_1002, 32'h0000_0777);
        // Over-long address length behaves as four bytes
        reconfig(1'b0, 8'h0B, 2'd1, 3'd7, 2'd1, 8'hA0, 4'd8, 2'd1, 1'b0);
        do_req(32'hA1B2_C3D4, 32'h0000_0000);

        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 99) < 15) random_reconfig();
            if ($urandom_range(0, 99) < 60) begin
                if ($urandom_range(0, 4) != 0) do_req(last_addr + 32'd1, last_addr);
                else do_req(last_addr + 32'd1, $urandom);
            end else begin
                do_req($urandom, $urandom);
            end
        end
        wait_idle();

        // Reset while an address op is being offered
        reconfig(1'b0, 8'h03, 2'd0, 3'd4, 2'd0, 8'h00, 4'd0, 2'd0, 1'b0);
        force_stall = 1'b1;
        do_req(32'h5566_7788, 32'h0000_0000);
        seen_tx = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            #2;
            if (io_link_tx_valid) begin
                seen_tx = 1'b1;
                break;
            end
        end
        check("stall_tx_valid_seen", 32'(seen_tx), 32'd1);
        check("stall_op_is_addr", 32'(io_link_tx_bits), 32'h55);
        @(negedge clock);
        reset = 1'b1;
        op_q.delete();
        rd_q.delete();
        m_ok = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        force_stall = 1'b0;
        #2;
        check("rst2_tx_valid", 32'(io_link_tx_valid), 32'd0);
        check("rst2_data_valid", 32'(io_data_valid), 32'd0);
        check("rst2_cs_clear", 32'(io_link_cs_clear), 32'd0);
        check("rst2_addr_ready_idle", 32'(io_addr_ready), 32'd1);
        io_en = 1'b0;
        #1;
        check("rst2_addr_ready_dis", 32'(io_addr_ready), 32'd0);
        repeat (5) begin
            @(negedge clock);
            #2;
            check("rst2_no_ops", 32'(io_link_tx_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/n101_qspi_flashmap_2.md
Name: n101_qspi_flashmap_2

Overview:
- Memory-mapped XIP read sequencer upstream of n101_qspi_media_2.
- Converts single-byte flash read requests (address in, byte out) into link transactions on the media's io_link_* interface: command byte, address bytes, optional pad/dummy op, then a receive op.
- Consecutive sequential reads are merged: chip select stays asserted and only the data op is reissued.

Parameters:
ADDR_W, 32, address width of io_addr_bits_next / io_addr_bits_hold (>= 8, <= 32)

Ports:
clock  in  1  sole clock
reset  in  1  synchronous, active-high reset
io_en  in  1  XIP enable; 0 = accept no requests and drop CS
io_ctrl_insn_cmd_en  in  1  send command byte when 1
io_ctrl_insn_cmd_code  in  8  flash command opcode
io_ctrl_insn_cmd_proto  in  2  proto for command (0 single, 1 dual, 2 quad)
io_ctrl_insn_addr_len  in  3  address bytes 0..4 (5..7 treated as 4)
io_ctrl_insn_addr_proto  in  2  proto for address bytes
io_ctrl_insn_pad_code  in  8  pad/mode byte value
io_ctrl_insn_pad_cnt  in  4  pad op bit count; 0 = no pad op
io_ctrl_insn_data_proto  in  2  proto for data op
io_ctrl_fmt_endian  in  1  passed to io_link_fmt_endian
io_addr_valid  in  1  request valid
io_addr_ready  out  1  request accepted when valid&ready
io_addr_bits_next  in  ADDR_W  byte address to read
io_addr_bits_hold  in  ADDR_W  address the requester held previously (merge check)
io_data_valid  out  1  read byte available
io_data_ready  in  1  consumer accepts byte
io_data_bits  out  8  read byte
io_link_tx_valid  out  1  op to media
io_link_tx_ready  in  1  media accepts op
io_link_tx_bits  out  8  op data
io_link_cnt  out  8  op bit count
io_link_fmt_proto  out  2  op proto
io_link_fmt_endian  out  1  op endian
io_link_fmt_iodir  out  1  1 = tx, 0 = rx
io_link_cs_set  out  1  constant 1
io_link_cs_clear  out  1  request CS deassert
io_link_cs_hold  out  1  keep CS after op
io_link_rx_valid  in  1  one-cycle received-byte pulse
io_link_rx_bits  in  8  received byte
io_link_active  in  1  media has CS asserted

Behaviour:
- Reset values: state IDLE, addr_ready 0, data_valid 0, data_bits 0, tx_valid 0, cs_clear 0, merge_ok 0, exp_addr 0.
- io_link_cs_set = 1; io_link_cs_hold = 1 in every op state; io_link_fmt_endian = io_ctrl_fmt_endian.
- Link op handshake: fire on tx_valid & tx_ready. Fields are stable while tx_valid is high. tx_valid never drops without a fire except on reset.
- FSM:
  - IDLE: io_addr_ready = io_en & !data_valid. On accept, latch addr_next into addr_r.
    - Merge if merge_ok & io_link_active & (addr_next == exp_addr) & (addr_next == addr_bits_hold + 1) -> DATA_REQ.
    - Else if io_link_active -> FLUSH.
    - Else -> CMD.
  - FLUSH: cs_clear = 1 until io_link_active == 0, then go to CMD.
  - CMD: if cmd_en, send cmd_code with cnt 8, cmd_proto, iodir 1. On fire, or immediately if !cmd_en, go to ADDR with byte counter = min(addr_len, 4).
  - ADDR: while counter != 0, send addr_r byte [8*counter-1 -: 8] (MSB first, zero-extended above ADDR_W), cnt 8, addr_proto, iodir 1. Decrement on fire. At 0 go to PAD.
  - PAD: if pad_cnt != 0, send pad_code with cnt = pad_cnt, addr_proto, iodir 1. Next state DATA_REQ after fire, or immediately when pad_cnt == 0.
  - DATA_REQ: send op with tx_bits 0, cnt 8, data_proto, iodir 0. On fire -> DATA_RESP.
  - DATA_RESP: wait for rx_valid, capture rx_bits into data_bits, set data_valid, set exp_addr = addr_r + 1 (wrap mod 2^ADDR_W), set merge_ok = 1, go to IDLE.
- data_valid clears on data_ready. A new request is not accepted while data_valid = 1. Because a byte is consumed before the next data op is issued, no rx byte can ever be dropped.
- io_en low in IDLE: cs_clear = 1 while io_link_active and merge_ok cleared. An in-flight transaction completes regardless.
- ctrl inputs are sampled live. Software changes them only while io_en = 0; any change with io_en = 0 invalidates merging, since merge_ok is cleared.
- rx_valid outside DATA_RESP is ignored.
- Synchronous reset mid-transaction returns to IDLE and discards the pending byte. The media is reset by the same reset.

Decomposition:
- Shared package: FSM state encoding (IDLE, FLUSH, CMD, ADDR, PAD, DATA_REQ, DATA_RESP) and proto constants (SINGLE=0, DUAL=1, QUAD=2).
- Single module, no sub-module needed. The output byte register is inline.

Test Plan:
- cmd_en=1, code 0x03, addr_len 3, pad_cnt 0, read 0x012345 -> ops 0x03, 0x01, 0x23, 0x45 (iodir 1), then rx op; rx 0xA5 returns data_bits 0xA5.
- Next request 0x012346 with hold 0x012345, link_active=1 -> only one DATA_REQ op, no cs_clear.
- Next request 0x000100 with link_active=1 -> cs_clear held until active falls, then full cmd/addr sequence.
- Quad fast read: code 0xEB proto 0, addr_proto 2, pad_code 0xFF, pad_cnt 6 -> pad op with cnt 6, proto 2; data op proto 2.
- Hold data_ready=0 for 10 cycles -> data_valid stays 1, addr_ready stays 0, no link ops; release -> next request accepted.
- Assert reset during ADDR with tx_valid high -> next cycle tx_valid 0, state IDLE, data_valid 0; io_en=0 afterwards -> addr_ready 0.
